// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one instruction-memory request at a time,
// holds the returned word in an output register and steers the PC on branches and redirects.
module fetch_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'hBFC00000,
    parameter logic [31:0] EXC_VEC   = 32'hBFC00380
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] PCCur,
    output logic        PCWEn,
    output logic [31:0] PCNext,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemRdata,
    output logic        InstValid,
    output logic [31:0] InstOut,
    output logic [31:0] InstPC,
    input  logic        Stall,
    input  logic        BrTaken,
    input  logic [31:0] BrTarget,
    input  logic        ExcReq,
    input  logic        EretReq,
    input  logic [31:0] EpcIn
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] req_addr;

    logic        consume;
    logic        redirect;
    logic        issue;
    logic        fill;
    logic [31:0] fill_addr;

    // Handshake decode: consume, issue and fill qualify the same cycle's inputs
    always_comb begin
        consume   = InstValid & ~Stall;
        redirect  = ExcReq | EretReq;
        issue     = ~Rst & (state == IDLE) & (~InstValid | consume) & ~redirect;
        fill      = ImemAck & ~redirect & (issue | (state == BUSY));
        fill_addr = (state == IDLE) ? PCCur : req_addr;
    end

    // Memory request and PC steering; a consumed branch is only ever seen in an issue cycle
    always_comb begin
        ImemReq  = 1'b0;
        ImemAddr = PCCur;
        PCWEn    = 1'b1;
        PCNext   = PCCur;
        if (Rst) begin
            PCNext = RESET_VEC;
        end else begin
            ImemReq  = issue | (state == BUSY) | (state == DRAIN);
            ImemAddr = (state == IDLE) ? PCCur : req_addr;
            if (ExcReq) begin
                PCNext = EXC_VEC;
            end else if (EretReq) begin
                PCNext = EpcIn;
            end else if (issue) begin
                if (BrTaken & consume) begin
                    PCNext = BrTarget;
                end else begin
                    PCWEn = 1'b0;
                end
            end else begin
                PCNext = PCCur;
            end
        end
    end

    // FSM, request address latch and output instruction register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            req_addr  <= 32'h0000_0000;
            InstValid <= 1'b0;
            InstOut   <= 32'h0000_0000;
            InstPC    <= 32'h0000_0000;
        end else begin
            if (issue) begin
                req_addr <= PCCur;
            end
            if (fill) begin
                InstOut <= ImemRdata;
                InstPC  <= fill_addr;
            end
            if (redirect) begin
                InstValid <= 1'b0;
            end else if (fill) begin
                InstValid <= 1'b1;
            end else if (consume) begin
                InstValid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (issue && !ImemAck) begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // An ack arriving with a redirect completes the request but the data is dropped
                    if (ImemAck) begin
                        state <= IDLE;
                    end else if (redirect) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (ImemAck) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: an open-loop vector table with hand-computed
// expectations, then closed-loop sequences with a PC register and memory model.
module tb_fetch_ctrl;

    localparam logic [31:0] RV = 32'hBFC00000;
    localparam logic [31:0] Z  = 32'h0000_0000;

    logic        Clk;
    logic        Rst;
    logic [31:0] PCCur;
    logic        PCWEn;
    logic [31:0] PCNext;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemRdata;
    logic        InstValid;
    logic [31:0] InstOut;
    logic [31:0] InstPC;
    logic        Stall;
    logic        BrTaken;
    logic [31:0] BrTarget;
    logic        ExcReq;
    logic        EretReq;
    logic [31:0] EpcIn;

    logic        use_model;
    logic        mem_ready;
    logic [31:0] pc_drv;
    logic        ack_drv;
    logic [31:0] rd_drv;
    logic [31:0] pc_model;

    int checks = 0;
    int errors = 0;

    fetch_ctrl dut (
        .Clk(Clk), .Rst(Rst), .PCCur(PCCur), .PCWEn(PCWEn), .PCNext(PCNext),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck), .ImemRdata(ImemRdata),
        .InstValid(InstValid), .InstOut(InstOut), .InstPC(InstPC), .Stall(Stall),
        .BrTaken(BrTaken), .BrTarget(BrTarget), .ExcReq(ExcReq), .EretReq(EretReq),
        .EpcIn(EpcIn)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // PC register model: increments by 4 unless a write is requested
    always @(posedge Clk) begin
        pc_model <= PCWEn ? PCNext : pc_model + 32'd4;
    end

    assign PCCur     = use_model ? pc_model : pc_drv;
    assign ImemAck   = use_model ? (ImemReq & mem_ready) : ack_drv;
    assign ImemRdata = use_model ? {16'h1000, ImemAddr[15:0]} : rd_drv;

    typedef struct {
        logic rst; logic [31:0] pc; logic ack; logic [31:0] rdata; logic stall;
        logic br; logic [31:0] tgt; logic exc; logic eret; logic [31:0] epc;
        logic e_wen; logic [31:0] e_next; logic e_req; logic [31:0] e_addr;
        logic e_iv; logic [31:0] e_iout; logic [31:0] e_ipc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        use_model = 1'b0; mem_ready = 1'b0;
        Rst = 1'b1; pc_drv = Z; ack_drv = 1'b0; rd_drv = Z;
        Stall = 1'b0; BrTaken = 1'b0; BrTarget = Z; ExcReq = 1'b0; EretReq = 1'b0; EpcIn = Z;

        //             rst   pc             ack   rdata          stl   br    tgt            exc   eret  epc             wen   next           req   addr           iv    iout           ipc
        vecs.push_back('{1'b1, Z,            1'b0, Z,            1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b1, RV,            1'b0, Z,            1'b0, Z,            Z});
        vecs.push_back('{1'b1, RV,           1'b1, 32'hDEADBEEF, 1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b1, RV,            1'b0, Z,            1'b0, Z,            Z});
        vecs.push_back('{1'b0, RV,           1'b1, 32'h10000000, 1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b0, Z,             1'b1, RV,           1'b0, Z,            Z});
        vecs.push_back('{1'b0, 32'hBFC00004, 1'b1, 32'h10000004, 1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b0, Z,             1'b1, 32'hBFC00004, 1'b1, 32'h10000000, RV});
        vecs.push_back('{1'b0, 32'hBFC00008, 1'b1, 32'h10000008, 1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b0, Z,             1'b1, 32'hBFC00008, 1'b1, 32'h10000004, 32'hBFC00004});
        vecs.push_back('{1'b0, 32'hBFC0000C, 1'b1, 32'h1000000C, 1'b1, 1'b0, Z,            1'b0, 1'b0, Z,            1'b1, 32'hBFC0000C,  1'b0, Z,            1'b1, 32'h10000008, 32'hBFC00008});
        vecs.push_back('{1'b0, 32'hBFC0000C, 1'b0, Z,            1'b1, 1'b0, Z,            1'b0, 1'b0, Z,            1'b1, 32'hBFC0000C,  1'b0, Z,            1'b1, 32'h10000008, 32'hBFC00008});
        vecs.push_back('{1'b0, 32'hBFC0000C, 1'b1, 32'h1000000C, 1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b0, Z,             1'b1, 32'hBFC0000C, 1'b1, 32'h10000008, 32'hBFC00008});
        vecs.push_back('{1'b0, 32'hBFC00010, 1'b1, 32'h10000010, 1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b0, Z,             1'b1, 32'hBFC00010, 1'b1, 32'h1000000C, 32'hBFC0000C});
        vecs.push_back('{1'b0, 32'hBFC00014, 1'b1, 32'h10000014, 1'b0, 1'b1, 32'hBFC00100, 1'b0, 1'b0, Z,            1'b1, 32'hBFC00100,  1'b1, 32'hBFC00014, 1'b1, 32'h10000010, 32'hBFC00010});
        vecs.push_back('{1'b0, 32'hBFC00100, 1'b1, 32'h10000100, 1'b1, 1'b1, 32'hBFC00200, 1'b0, 1'b0, Z,            1'b1, 32'hBFC00100,  1'b0, Z,            1'b1, 32'h10000014, 32'hBFC00014});
        vecs.push_back('{1'b0, 32'hBFC00100, 1'b0, Z,            1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b0, Z,             1'b1, 32'hBFC00100, 1'b1, 32'h10000014, 32'hBFC00014});
        vecs.push_back('{1'b0, 32'hBFC00104, 1'b0, Z,            1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b1, 32'hBFC00104,  1'b1, 32'hBFC00100, 1'b0, 32'h10000014, 32'hBFC00014});
        vecs.push_back('{1'b0, 32'hBFC00104, 1'b1, 32'h10000100, 1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b1, 32'hBFC00104,  1'b1, 32'hBFC00100, 1'b0, 32'h10000014, 32'hBFC00014});
        vecs.push_back('{1'b0, 32'hBFC00104, 1'b0, Z,            1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b0, Z,             1'b1, 32'hBFC00104, 1'b1, 32'h10000100, 32'hBFC00100});
        vecs.push_back('{1'b0, 32'hBFC00108, 1'b0, Z,            1'b0, 1'b1, 32'hBFC00200, 1'b1, 1'b0, Z,            1'b1, 32'hBFC00380,  1'b1, 32'hBFC00104, 1'b0, 32'h10000100, 32'hBFC00100});
        vecs.push_back('{1'b0, 32'hBFC00380, 1'b0, Z,            1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b1, 32'hBFC00380,  1'b1, 32'hBFC00104, 1'b0, 32'h10000100, 32'hBFC00100});
        vecs.push_back('{1'b0, 32'hBFC00380, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b1, 32'hBFC00380,  1'b1, 32'hBFC00104, 1'b0, 32'h10000100, 32'hBFC00100});
        vecs.push_back('{1'b0, 32'hBFC00380, 1'b1, 32'h10000380, 1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b0, Z,             1'b1, 32'hBFC00380, 1'b0, 32'h10000100, 32'hBFC00100});
        vecs.push_back('{1'b0, 32'hBFC00384, 1'b1, 32'h10000384, 1'b0, 1'b1, 32'hBFC00200, 1'b1, 1'b0, Z,            1'b1, 32'hBFC00380,  1'b0, Z,            1'b1, 32'h10000380, 32'hBFC00380});
        vecs.push_back('{1'b0, 32'hBFC00380, 1'b1, 32'h10000380, 1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b0, Z,             1'b1, 32'hBFC00380, 1'b0, 32'h10000380, 32'hBFC00380});
        vecs.push_back('{1'b0, 32'hBFC00384, 1'b0, Z,            1'b1, 1'b0, Z,            1'b0, 1'b1, 32'hBFC00044, 1'b1, 32'hBFC00044,  1'b0, Z,            1'b1, 32'h10000380, 32'hBFC00380});
        vecs.push_back('{1'b0, 32'hBFC00044, 1'b1, 32'h10000044, 1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b0, Z,             1'b1, 32'hBFC00044, 1'b0, 32'h10000380, 32'hBFC00380});
        vecs.push_back('{1'b0, 32'hBFC00048, 1'b0, Z,            1'b0, 1'b0, Z,            1'b1, 1'b1, 32'hBFC00044, 1'b1, 32'hBFC00380,  1'b0, Z,            1'b1, 32'h10000044, 32'hBFC00044});
        vecs.push_back('{1'b0, 32'hBFC00380, 1'b0, Z,            1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b0, Z,             1'b1, 32'hBFC00380, 1'b0, 32'h10000044, 32'hBFC00044});
        vecs.push_back('{1'b0, 32'hBFC00384, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, Z,            1'b0, 1'b1, 32'hBFC00044, 1'b1, 32'hBFC00044,  1'b1, 32'hBFC00380, 1'b0, 32'h10000044, 32'hBFC00044});
        vecs.push_back('{1'b0, 32'hBFC00044, 1'b0, Z,            1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b0, Z,             1'b1, 32'hBFC00044, 1'b0, 32'h10000044, 32'hBFC00044});
        vecs.push_back('{1'b1, 32'hBFC00048, 1'b0, Z,            1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b1, RV,            1'b0, Z,            1'b0, 32'h10000044, 32'hBFC00044});
        vecs.push_back('{1'b0, RV,           1'b1, 32'h10000000, 1'b0, 1'b0, Z,            1'b0, 1'b0, Z,            1'b0, Z,             1'b1, RV,           1'b0, Z,            Z});
        vecs.push_back('{1'b0, 32'hBFC00004, 1'b0, Z,            1'b1, 1'b0, Z,            1'b0, 1'b0, Z,            1'b1, 32'hBFC00004,  1'b0, Z,            1'b1, 32'h10000000, RV});

        repeat (2) @(posedge Clk);

        foreach (vecs[k]) begin
            @(posedge Clk);
            #1;
            Rst = vecs[k].rst; pc_drv = vecs[k].pc; ack_drv = vecs[k].ack; rd_drv = vecs[k].rdata;
            Stall = vecs[k].stall; BrTaken = vecs[k].br; BrTarget = vecs[k].tgt;
            ExcReq = vecs[k].exc; EretReq = vecs[k].eret; EpcIn = vecs[k].epc;
            @(negedge Clk);
            chk("pcwen", k, 32'(PCWEn), 32'(vecs[k].e_wen));
            if (vecs[k].e_wen) chk("pcnext", k, PCNext, vecs[k].e_next);
            chk("imemreq", k, 32'(ImemReq), 32'(vecs[k].e_req));
            if (vecs[k].e_req) chk("imemaddr", k, ImemAddr, vecs[k].e_addr);
            chk("instvalid", k, 32'(InstValid), 32'(vecs[k].e_iv));
            chk("instout", k, InstOut, vecs[k].e_iout);
            chk("instpc", k, InstPC, vecs[k].e_ipc);
        end

        // Closed loop, single-cycle memory: back-to-back fetches after reset release
        @(posedge Clk);
        #1;
        use_model = 1'b1; Rst = 1'b1; mem_ready = 1'b0;
        Stall = 1'b0; BrTaken = 1'b0; ExcReq = 1'b0; EretReq = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk("seq1_req", i, 32'(ImemReq), 32'd1);
            chk("seq1_addr", i, ImemAddr, RV + 32'(4 * i));
            chk("seq1_iv", i, 32'(InstValid), (i > 0) ? 32'd1 : 32'd0);
            if (i > 0) begin
                chk("seq1_ipc", i, InstPC, RV + 32'(4 * (i - 1)));
                chk("seq1_iout", i, InstOut, 32'h10000000 + 32'(4 * (i - 1)));
            end
            @(posedge Clk);
            #1;
        end

        // Closed loop, ack delayed three cycles, then stall and release
        Rst = 1'b1; mem_ready = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            @(negedge Clk);
            chk("seq2_req", i, 32'(ImemReq), 32'd1);
            chk("seq2_addr", i, ImemAddr, RV);
            chk("seq2_iv", i, 32'(InstValid), 32'd0);
            if (i > 0) begin
                chk("seq2_wen", i, 32'(PCWEn), 32'd1);
                chk("seq2_next", i, PCNext, RV + 32'd4);
            end
            @(posedge Clk);
            #1;
        end
        Stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("seq3_iv", i, 32'(InstValid), 32'd1);
            chk("seq3_ipc", i, InstPC, RV);
            chk("seq3_iout", i, InstOut, 32'h10000000);
            chk("seq3_req", i, 32'(ImemReq), 32'd0);
            chk("seq3_next", i, PCNext, RV + 32'd4);
            @(posedge Clk);
            #1;
        end
        Stall = 1'b0;
        @(negedge Clk);
        chk("seq3_issue_req", 0, 32'(ImemReq), 32'd1);
        chk("seq3_issue_addr", 0, ImemAddr, RV + 32'd4);
        @(posedge Clk);
        #1;
        @(negedge Clk);
        chk("seq3_after_ipc", 0, InstPC, RV + 32'd4);
        chk("seq3_after_iv", 0, 32'(InstValid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_VEC, default 32'hBFC00000, PC value forced while Rst is high.
REQ-002 Parameter EXC_VEC, default 32'hBFC00380, PC value loaded on ExcReq.
REQ-003 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-004 Rst  input  1  reset, synchronous, active-high.
REQ-005 PCCur  input  32  current value of the PC register.
REQ-006 PCWEn  output  1  PC write enable; 0 means the PC register increments by 4.
REQ-007 PCNext  output  32  PC write data, used when PCWEn=1.
REQ-008 ImemReq  output  1  instruction memory request.
REQ-009 ImemAddr  output  32  request address, stable while ImemReq=1.
REQ-010 ImemAck  input  1  memory completion, may be high in the issue cycle or any later cycle.
REQ-011 ImemRdata  input  32  instruction word, valid when ImemAck=1.
REQ-012 InstValid  output  1  output register holds an unconsumed instruction.
REQ-013 InstOut  output  32  instruction word in the output register.
REQ-014 InstPC  output  32  fetch address of InstOut.
REQ-015 Stall  input  1  downstream not ready; consume = InstValid & !Stall.
REQ-016 BrTaken  input  1  taken branch or jump, sampled only in a consume cycle.
REQ-017 BrTarget  input  32  branch or jump target.
REQ-018 ExcReq  input  1  exception redirect, any cycle.
REQ-019 EretReq  input  1  return-from-exception redirect, any cycle.
REQ-020 EpcIn  input  32  ERET target.

Function
REQ-021 FSM states: IDLE (nothing outstanding), BUSY (one fetch outstanding, data kept), DRAIN (one fetch outstanding, data discarded).
REQ-022 At most one fetch SHALL be outstanding or held in the output register at any time.
REQ-023 Issue condition: state IDLE & (!InstValid | consume) & !ExcReq & !EretReq.
REQ-024 Issue cycle: ImemReq=1, ImemAddr=PCCur, PCCur latched into ReqAddr, PCWEn=0 (PC+4); if BrTaken & consume, PCWEn=1 and PCNext=BrTarget instead.
REQ-025 Issue without ImemAck moves IDLE->BUSY; issue with ImemAck in the same cycle fills the output register and stays IDLE.
REQ-026 BUSY/DRAIN: ImemReq=1 and ImemAddr=ReqAddr every cycle until ImemAck; the request is never withdrawn.
REQ-027 Ack in IDLE-issue or BUSY: next cycle InstValid=1, InstOut=ImemRdata, InstPC=request address; then state IDLE.
REQ-028 Ack in DRAIN: data dropped, InstValid unchanged, state IDLE.
REQ-029 Consume without a same-cycle fill clears InstValid next cycle.
REQ-030 Stall=1 with InstValid=1: InstOut, InstPC and InstValid hold, and no new issue occurs.
REQ-031 Cycles with no issue and no redirect: PCWEn=1, PCNext=PCCur (PC holds).
REQ-032 ExcReq: PCWEn=1, PCNext=EXC_VEC, InstValid cleared next cycle, no issue; BUSY->DRAIN, IDLE stays IDLE, DRAIN stays DRAIN (or IDLE if acked that cycle).
REQ-033 EretReq: same as ExcReq except PCNext=EpcIn.
REQ-034 Priority: ExcReq > EretReq > BrTaken; a simultaneous BrTaken is ignored.
REQ-035 Ack coinciding with ExcReq/EretReq in BUSY: data dropped, state IDLE.
REQ-036 BrTaken outside a consume cycle SHALL be ignored.
REQ-037 The delay-slot instruction (fetched at branch+4) SHALL be delivered; the next fetch is from BrTarget.

Reset
REQ-038 Rst=1: state IDLE, InstValid=0, InstOut=0, InstPC=0, ReqAddr=0, ImemReq=0, PCWEn=1, PCNext=RESET_VEC.
REQ-039 Rst overrides all inputs; a fetch outstanding at reset is abandoned, and a late ImemAck in the first cycles after reset is ignored unless ImemReq=1.
REQ-040 First issue occurs in the first cycle after Rst falls, at PCCur=RESET_VEC.

Verification
REQ-041 Reset release, single-cycle memory, Stall=0 -> ImemAddr BFC00000, BFC00004, BFC00008 on consecutive cycles; InstValid=1 from cycle 2 with matching InstPC.
REQ-042 Ack delayed 3 cycles for BFC00000 -> ImemReq and ImemAddr held 4 cycles, PCWEn=1 with PCNext=PCCur=BFC00004 during the wait, one InstValid fill.
REQ-043 Stall=1 for 5 cycles with InstValid=1 -> InstOut/InstPC constant, ImemReq=0; Stall falls -> consume and issue in the same cycle.
REQ-044 Branch at BFC00010 consumed with BrTaken=1, BrTarget=BFC00100 -> next fetches BFC00014 (delay slot), then BFC00100.
REQ-045 ExcReq during BUSY (addr BFC00020, ack 2 cycles later) -> DRAIN, that data dropped, next fetch EXC_VEC BFC00380; ExcReq+BrTaken together -> EXC_VEC wins.
REQ-046 EretReq with EpcIn=BFC00044 while InstValid=1 -> InstValid cleared next cycle, next fetch BFC00044.
